// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Shared constants and fetch-state encoding for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // All-zero word (sll $0,$0,0) used as the bubble / faulted instruction.
  localparam logic [31:0] c_NOP = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam int unsigned c_INSTR_BYTES = 4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Brief    : IF/ID pipeline register with load / hold / flush / consume.
//             Flush only kills the valid bit; payload is left as-is.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              consume_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] pc_plus4_i,
  input  logic              fault_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              fault_o
);

  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4_q;
  logic              fault_q;

  // Valid bit: flush beats load beats consume; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload: only a non-flushed load overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      fault_q    <= 1'b0;
    end else if (load_i && !flush_i) begin
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
      fault_q    <= fault_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign fault_o    = fault_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch stage. Issues one imem read at a time for the
//             current pc, fills IF/ID, steers next_pc back into the PC
//             register (hold / +4 / redirect) and drains responses that a
//             redirect has made stale.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              if_fault
);

  fetch_state_e state_q, state_d;

  logic              misaligned;
  logic              slot_free;
  logic              issue;
  logic              fault_cap;
  logic              rsp_cap;
  logic              capture;
  logic [ADDR_W-1:0] pc_plus4;
  logic [DATA_W-1:0] load_instr;

  assign misaligned = |pc[1:0];
  // IF/ID can take a new entry if it is empty or decode drains it this cycle.
  assign slot_free  = !if_valid || id_ready;
  assign pc_plus4   = pc + ADDR_W'(c_INSTR_BYTES);

  // State register; reset drops straight back to IDLE even mid-fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, request handshake, capture decision and next_pc mux.
  always_comb begin
    state_d        = state_q;
    issue          = 1'b0;
    fault_cap      = 1'b0;
    rsp_cap        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (slot_free) begin
          if (misaligned) begin
            // No memory access; the fault itself becomes the fetched item.
            fault_cap = !redirect_valid;
          end else begin
            issue = 1'b1;
            if (imem_req_ready) begin
              state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        // IF/ID was free when the request went out and nothing else loads it
        // meanwhile, so a response can always be captured.
        if (imem_rsp_valid) begin
          rsp_cap = !redirect_valid;
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    capture = fault_cap || rsp_cap;

    if (redirect_valid) begin
      next_pc = redirect_target;
    end else if (capture) begin
      next_pc = pc_plus4;
    end else begin
      next_pc = pc;
    end

    load_instr = fault_cap ? DATA_W'(c_NOP) : imem_rsp_data;
  end

  assign imem_req_valid = issue;
  assign imem_req_addr  = pc;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (capture),
    .flush_i    (redirect_valid),
    .consume_i  (id_ready && if_valid),
    .instr_i    (load_instr),
    .pc_i       (pc),
    .pc_plus4_i (pc_plus4),
    .fault_i    (fault_cap),
    .valid_o    (if_valid),
    .instr_o    (if_instr),
    .pc_o       (if_pc),
    .pc_plus4_o (if_pc_plus4),
    .fault_o    (if_fault)
  );

endmodule
`default_nettype wire
